// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier result path.
package mul_pkg;
    localparam int DATA_LEN    = 8;
    localparam int TAG_W       = 4;
    localparam int FUNC3_WIDTH = 3;

    localparam logic [FUNC3_WIDTH-1:0] MUL    = 3'b000;
    localparam logic [FUNC3_WIDTH-1:0] MULH   = 3'b001;
    localparam logic [FUNC3_WIDTH-1:0] MULHSU = 3'b010;
    localparam logic [FUNC3_WIDTH-1:0] MULHU  = 3'b011;

    typedef struct packed {
        logic [DATA_LEN-1:0] data;
        logic [TAG_W-1:0]    tag;
    } mul_res_t;
endpackage

// File: rtl/mul_res_fifo.sv
// DEPTH-entry FIFO of mul_res_t with synchronous flush; head is always visible on rdata.
module mul_res_fifo
    import mul_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  mul_res_t                 wdata,
    output mul_res_t                 rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    mul_res_t         r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    // Storage carries no reset; nothing reads it while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !flush)
            r_mem[r_wptr] <= wdata;
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push)
                r_wptr <= r_wptr + AW'(1);
            if (pop)
                r_rptr <= r_rptr + AW'(1);
            if (push && !pop)
                r_count <= r_count + CW'(1);
            else if (pop && !push)
                r_count <= r_count - CW'(1);
        end
    end

    assign rdata = r_mem[r_rptr];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
endmodule

// File: rtl/mul_result_stage_8bit.sv
// Buffers multiplier tree output, selects the M-extension result half at push time,
// and presents it to writeback over valid/ready while counting stall cycles.
module mul_result_stage_8bit #(
    parameter int DATA_LEN = 8,
    parameter int TAG_W    = 4,
    parameter int DEPTH    = 2,
    parameter int STALL_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_LEN-1:0] in_product,
    input  logic [2:0]            in_func3,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_LEN-1:0]   out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic [STALL_W-1:0]    stall_cnt
);
    import mul_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    function automatic logic [DATA_LEN-1:0] sel_half(
        input logic [2*DATA_LEN-1:0] product,
        input logic [2:0]            func3
    );
        case (func3)
            MULH, MULHSU, MULHU: sel_half = product[2*DATA_LEN-1:DATA_LEN];
            default:             sel_half = product[DATA_LEN-1:0];
        endcase
    endfunction

    mul_res_t             w_wdata;
    mul_res_t             w_head;
    logic [CW-1:0]        w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [STALL_W-1:0]   r_stall_cnt;

    assign w_wdata.data = sel_half(in_product, in_func3);
    assign w_wdata.tag  = in_tag;

    // in_ready depends only on occupancy and flush, never on out_ready.
    assign in_ready  = ~w_full & ~flush;
    assign out_valid = (w_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign out_data  = w_empty ? '0 : w_head.data;
    assign out_tag   = w_empty ? '0 : w_head.tag;
    assign stall_cnt = r_stall_cnt;

    mul_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Saturating; flush deliberately leaves the history intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (out_valid && !out_ready && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end
endmodule
